hazard_stall_ctrl: RTL and testbench

- Drives the freeze/clear controls that the IF/ID and ID/EX pipeline registers consume: PC/IF-ID freeze and the ID/EX bubble insertion.
- Detects load-use hazards, branch-operand hazards resolved in ID, and multiply/divide unit occupancy, which is tracked by an internal busy counter.
- Sits beside the ID stage and reads ID-stage operand fields plus EX and MEM destination/control fields.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Generates the pipeline freeze/bubble controls that sit beside the ID stage:
// the PC and IF/ID register are held and a bubble is loaded into ID/EX when
// the instruction in ID cannot proceed this cycle.
//
// Three hazard sources are detected, all combinationally and in the same
// cycle:
//   loaduse - ID reads a register that the load now in EX will write.
//   branch  - a branch/jr compares its operands in ID. It depends on any GPR
//             write still in EX, or on a load still in MEM.
//   md      - ID uses the mult/div unit while that unit is still busy.
//
// Mult/div occupancy is tracked by md_cnt. md_cnt is loaded when a
// mult/div issues from EX and then counts down to zero.
// A saturating counter records the total number of stall cycles.
//
// Ports:
//   CLK            in   pipeline clock, rising edge
//   Reset          in   asynchronous, active-high reset
//   IDrs/IDrt      in   source register fields of the ID instruction
//   IDUseRs/Rt     in   ID instruction actually reads rs / rt
//   IDBranch       in   ID instruction compares its operands in ID
//   IDMDUse        in   ID instruction uses the mult/div unit or HI/LO
//   EXWriteReg     in   EX destination register
//   EXRegWrite     in   EX instruction writes a GPR
//   EXRegWriteSrc  in   EX write-back source (2'b01 = data memory)
//   EXMDStart      in   EX instruction is mult/multu/div/divu
//   EXMDDiv        in   qualifies EXMDStart: 1 = divide, 0 = multiply
//   MEMWriteReg    in   MEM destination register
//   MEMRegWrite    in   MEM instruction writes a GPR
//   MEMRegWriteSrc in   MEM write-back source (same encoding)
//   PCFrozen       out  hold PC
//   IFIDFrozen     out  hold IF/ID register
//   IDEXClear      out  load a bubble into ID/EX
//   MDBusy         out  mult/div unit busy, including its issue cycle
//   StallCause     out  {md, branch, loaduse} for the current cycle
//   StallCount     out  stall cycles since reset, saturating
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int LAT_W       = 4,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic             IDUseRs,
  input  logic             IDUseRt,
  input  logic             IDBranch,
  input  logic             IDMDUse,
  input  logic [4:0]       EXWriteReg,
  input  logic             EXRegWrite,
  input  logic [1:0]       EXRegWriteSrc,
  input  logic             EXMDStart,
  input  logic             EXMDDiv,
  input  logic [4:0]       MEMWriteReg,
  input  logic             MEMRegWrite,
  input  logic [1:0]       MEMRegWriteSrc,
  output logic             PCFrozen,
  output logic             IFIDFrozen,
  output logic             IDEXClear,
  output logic             MDBusy,
  output logic [2:0]       StallCause,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [1:0]       SRC_DMEM  = 2'b01;
  localparam logic [LAT_W-1:0] MULT_LOAD = LAT_W'(MULT_CYCLES);
  localparam logic [LAT_W-1:0] DIV_LOAD  = LAT_W'(DIV_CYCLES);

  logic [LAT_W-1:0] md_cnt;
  logic             ex_hit;
  logic             mem_hit;
  logic             loaduse;
  logic             branch;
  logic             md;
  logic             stall;

  // True when register x is a real (non-$0) source operand of the ID instruction.
  function automatic logic src_hit(input logic [4:0] x,
                                   input logic [4:0] rs, input logic use_rs,
                                   input logic [4:0] rt, input logic use_rt);
    return (x != 5'd0) && (((x == rs) && use_rs) || ((x == rt) && use_rt));
  endfunction

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    ex_hit  = 1'b0;
    mem_hit = 1'b0;
    loaduse = 1'b0;
    branch  = 1'b0;
    md      = 1'b0;
    MDBusy  = 1'b0;

    ex_hit  = src_hit(EXWriteReg,  IDrs, IDUseRs, IDrt, IDUseRt);
    mem_hit = src_hit(MEMWriteReg, IDrs, IDUseRs, IDrt, IDUseRt);

    // Reset must silence every control, even though EXMDStart and the
    // operand fields may still be toggling while reset is high.
    if (!Reset) begin
      loaduse = EXRegWrite && (EXRegWriteSrc == SRC_DMEM) && ex_hit;
      // An ALU result still in MEM can be forwarded to the ID comparator.
      // A load in MEM cannot be forwarded, because its data is not ready yet.
      branch  = IDBranch &&
                ((EXRegWrite && ex_hit) ||
                 (MEMRegWrite && (MEMRegWriteSrc == SRC_DMEM) && mem_hit));
      MDBusy  = (md_cnt != '0) || EXMDStart;
      md      = IDMDUse && MDBusy;
    end
  end

  assign stall      = loaduse | branch | md;
  assign PCFrozen   = stall;
  assign IFIDFrozen = stall;
  assign IDEXClear  = stall;
  assign StallCause = {md, branch, loaduse};

  // A new mult/div issue always reloads the counter, even if it is still
  // counting down; the most recent operation determines availability.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      md_cnt <= '0;
    end else if (EXMDStart) begin
      md_cnt <= EXMDDiv ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
    end else if (stall && (StallCount != '1)) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for hazard_stall_ctrl.
// Two instances share the same stimulus. u_dut uses the default 32-bit stall
// counter, and u_sat uses a 4-bit counter so that saturation can be reached.
// For each stimulus cycle, hand-derived expectations are pushed to a queue.
// After the outputs settle, the entry is popped and compared.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [4:0]  IDrs, IDrt, EXWriteReg, MEMWriteReg;
  logic        IDUseRs, IDUseRt, IDBranch, IDMDUse;
  logic        EXRegWrite, EXMDStart, EXMDDiv, MEMRegWrite;
  logic [1:0]  EXRegWriteSrc, MEMRegWriteSrc;

  logic        pc_frozen, ifid_frozen, idex_clear, md_busy;
  logic [2:0]  stall_cause;
  logic [31:0] stall_count;

  logic        s_pc_frozen, s_ifid_frozen, s_idex_clear, s_md_busy;
  logic [2:0]  s_stall_cause;
  logic [3:0]  s_stall_count;

  always #5 CLK = ~CLK;

  hazard_stall_ctrl u_dut (
    .CLK(CLK), .Reset(Reset),
    .IDrs(IDrs), .IDrt(IDrt), .IDUseRs(IDUseRs), .IDUseRt(IDUseRt),
    .IDBranch(IDBranch), .IDMDUse(IDMDUse),
    .EXWriteReg(EXWriteReg), .EXRegWrite(EXRegWrite), .EXRegWriteSrc(EXRegWriteSrc),
    .EXMDStart(EXMDStart), .EXMDDiv(EXMDDiv),
    .MEMWriteReg(MEMWriteReg), .MEMRegWrite(MEMRegWrite), .MEMRegWriteSrc(MEMRegWriteSrc),
    .PCFrozen(pc_frozen), .IFIDFrozen(ifid_frozen), .IDEXClear(idex_clear),
    .MDBusy(md_busy), .StallCause(stall_cause), .StallCount(stall_count)
  );

  hazard_stall_ctrl #(.CNT_W(4)) u_sat (
    .CLK(CLK), .Reset(Reset),
    .IDrs(IDrs), .IDrt(IDrt), .IDUseRs(IDUseRs), .IDUseRt(IDUseRt),
    .IDBranch(IDBranch), .IDMDUse(IDMDUse),
    .EXWriteReg(EXWriteReg), .EXRegWrite(EXRegWrite), .EXRegWriteSrc(EXRegWriteSrc),
    .EXMDStart(EXMDStart), .EXMDDiv(EXMDDiv),
    .MEMWriteReg(MEMWriteReg), .MEMRegWrite(MEMRegWrite), .MEMRegWriteSrc(MEMRegWriteSrc),
    .PCFrozen(s_pc_frozen), .IFIDFrozen(s_ifid_frozen), .IDEXClear(s_idex_clear),
    .MDBusy(s_md_busy), .StallCause(s_stall_cause), .StallCount(s_stall_count)
  );

  typedef struct {
    string      tag;
    logic [2:0] cause;
    logic       busy;
    int         cnt;
    int         cnt4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;
  int   exp_cnt4 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    IDrs = '0; IDrt = '0; IDUseRs = 0; IDUseRt = 0; IDBranch = 0; IDMDUse = 0;
    EXWriteReg = '0; EXRegWrite = 0; EXRegWriteSrc = '0; EXMDStart = 0; EXMDDiv = 0;
    MEMWriteReg = '0; MEMRegWrite = 0; MEMRegWriteSrc = '0;
  endtask

  task automatic push_exp(input string tag, input logic [2:0] cause, input logic busy);
    exp_t e;
    e.tag = tag; e.cause = cause; e.busy = busy; e.cnt = exp_cnt; e.cnt4 = exp_cnt4;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".cause"}, 32'(stall_cause), 32'(e.cause));
    check({e.tag, ".pc"},    32'(pc_frozen),   32'(|e.cause));
    check({e.tag, ".ifid"},  32'(ifid_frozen), 32'(|e.cause));
    check({e.tag, ".idex"},  32'(idex_clear),  32'(|e.cause));
    check({e.tag, ".busy"},  32'(md_busy),     32'(e.busy));
    check({e.tag, ".cnt"},   stall_count,      32'(e.cnt));
    check({e.tag, ".cnt4"},  32'(s_stall_count), 32'(e.cnt4));
  endtask

  // Called at posedge+1, with inputs already driven for this cycle. Outputs are
  // sampled at posedge+3, and the cycle ends at the next posedge+1.
  task automatic cycle(input string tag, input logic [2:0] cause, input logic busy);
    push_exp(tag, cause, busy);
    #2;
    compare_out();
    @(posedge CLK);
    if (|cause) begin
      exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    Reset = 1'b1;
    // With reset held, hazard-producing inputs must leave every output at zero.
    EXRegWrite = 1; EXRegWriteSrc = 2'b01; EXWriteReg = 5'd8;
    IDrs = 5'd8; IDUseRs = 1; EXMDStart = 1; IDMDUse = 1;
    #2;
    push_exp("reset", 3'b000, 1'b0);
    compare_out();
    clear_inputs();
    @(posedge CLK); #1;
    Reset = 1'b0;

    // Load-use hazards.
    EXRegWrite = 1; EXRegWriteSrc = 2'b01; EXWriteReg = 5'd8; IDrs = 5'd8; IDUseRs = 1;
    cycle("lu_rs", 3'b001, 1'b0);
    EXWriteReg = 5'd0; IDrs = 5'd0;
    cycle("lu_r0", 3'b000, 1'b0);
    EXWriteReg = 5'd12; IDrs = 5'd3; IDrt = 5'd12; IDUseRt = 1;
    cycle("lu_rt", 3'b001, 1'b0);
    IDUseRt = 0;
    cycle("lu_nouse", 3'b000, 1'b0);
    IDUseRt = 1; EXRegWriteSrc = 2'b00;
    cycle("alu_nobr", 3'b000, 1'b0);

    // A branch that depends on a load stalls for two cycles.
    clear_inputs();
    EXRegWrite = 1; EXRegWriteSrc = 2'b01; EXWriteReg = 5'd9;
    IDrs = 5'd9; IDUseRs = 1; IDBranch = 1;
    cycle("br_ld1", 3'b011, 1'b0);
    EXRegWrite = 0; EXRegWriteSrc = 2'b00; EXWriteReg = 5'd0;
    MEMRegWrite = 1; MEMRegWriteSrc = 2'b01; MEMWriteReg = 5'd9;
    cycle("br_ld2", 3'b010, 1'b0);
    MEMRegWrite = 0; MEMWriteReg = 5'd0; MEMRegWriteSrc = 2'b00;
    cycle("br_ld3", 3'b000, 1'b0);
    // A branch that depends on an ALU result stalls while the result is in EX.
    // Once the result reaches MEM, it can be forwarded.
    EXRegWrite = 1; EXRegWriteSrc = 2'b00; EXWriteReg = 5'd9;
    cycle("br_alu", 3'b010, 1'b0);
    clear_inputs();
    IDrs = 5'd9; IDUseRs = 1; IDBranch = 1;
    MEMRegWrite = 1; MEMRegWriteSrc = 2'b00; MEMWriteReg = 5'd9;
    cycle("br_memalu", 3'b000, 1'b0);

    // A multiply followed by mflo stalls for the EX cycle plus five more cycles.
    clear_inputs();
    EXMDStart = 1; EXMDDiv = 0; IDMDUse = 1;
    cycle("mul0", 3'b100, 1'b1);
    EXMDStart = 0;
    for (int i = 1; i <= 5; i++) cycle($sformatf("mul%0d", i), 3'b100, 1'b1);
    cycle("mul_done", 3'b000, 1'b0);

    // A divide is reloaded by a multiply issued three cycles later.
    clear_inputs();
    EXMDStart = 1; EXMDDiv = 1;
    cycle("div0", 3'b000, 1'b1);
    EXMDStart = 0; EXMDDiv = 0;
    cycle("div1", 3'b000, 1'b1);
    cycle("div2", 3'b000, 1'b1);
    EXMDStart = 1; EXMDDiv = 0;
    cycle("reload", 3'b000, 1'b1);
    EXMDStart = 0;
    for (int i = 1; i <= 5; i++) cycle($sformatf("rl%0d", i), 3'b000, 1'b1);
    IDMDUse = 1;
    cycle("rl_done", 3'b000, 1'b0);

    // Asynchronous reset during a divide, asserted between clock edges.
    clear_inputs();
    EXMDStart = 1; EXMDDiv = 1;
    cycle("rdiv0", 3'b000, 1'b1);
    EXMDStart = 0; EXMDDiv = 0;
    cycle("rdiv1", 3'b000, 1'b1);
    cycle("rdiv2", 3'b000, 1'b1);
    cycle("rdiv3", 3'b000, 1'b1);
    IDMDUse = 1;                                  // md_cnt is 7 at this point
    push_exp("pre_rst", 3'b100, 1'b1);
    #2;
    compare_out();
    Reset = 1'b1;
    exp_cnt = 0; exp_cnt4 = 0;
    push_exp("async_rst", 3'b000, 1'b0);
    #1;
    compare_out();
    @(posedge CLK); #1;
    Reset = 1'b0;
    cycle("post_rst", 3'b000, 1'b0);

    // Saturation: hold a load-use hazard for 20 cycles. The 4-bit counter sticks at 15.
    clear_inputs();
    EXRegWrite = 1; EXRegWriteSrc = 2'b01; EXWriteReg = 5'd20; IDrt = 5'd20; IDUseRt = 1;
    for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i), 3'b001, 1'b0);
    clear_inputs();
    #2;
    check("sat_final4", 32'(s_stall_count), 32'd15);
    check("sat_final32", stall_count, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
